// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and helpers for the BCD up/down counter: 7-segment
// patterns (active-low {g,f,e,d,c,b,a}), the decade limit and decode helpers.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Decode one BCD digit; anything outside 0-9 shows a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    // Saturate a nibble into the legal BCD range.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One decade of the counter. Holds a single BCD digit, steps it up or down
// with wrap when 'step' is high, and reports whether it sits at the value
// that makes it pass a carry/borrow to the next decade.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Load,
    input  logic [3:0] LoadDigit,
    input  logic       step,
    input  logic       Up,
    output logic [3:0] digit,
    output logic       term
);

    logic [3:0] r_digit;
    logic [3:0] w_next_step;

    // Next value when stepping: 9 wraps to 0 going up, 0 wraps to 9 going down.
    always_comb begin
        w_next_step = r_digit;
        if (Up) begin
            w_next_step = (r_digit >= BCD_MAX) ? 4'd0 : r_digit + 4'd1;
        end else begin
            w_next_step = (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
        end
    end

    // Digit register: reset beats load beats step.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_digit <= 4'd0;
        end else if (Load) begin
            r_digit <= bcd_clamp(LoadDigit);
        end else if (step) begin
            r_digit <= w_next_step;
        end
    end

    assign digit = r_digit;
    assign term  = Up ? (r_digit == BCD_MAX) : (r_digit == 4'd0);

endmodule

// File: rtl/bcd_updown_counter.sv
// N-decade BCD up/down counter with synchronous load, enable, a one-cycle
// terminal-count pulse on wrap and active-low 7-segment outputs per digit.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  En,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadVal,
    output logic [4*DIGITS-1:0]   Count,
    output logic                  Tc,
    output logic [7*DIGITS-1:0]   HEX
);

    logic [DIGITS-1:0][3:0] w_digit;
    logic [DIGITS-1:0]      w_term;
    // w_carry[i] is the step for decade i; w_carry[DIGITS] means the whole
    // counter wraps on this edge.
    logic [DIGITS:0]        w_carry;
    logic                   r_tc;

    assign w_carry[0] = En;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign w_carry[g+1] = w_carry[g] & w_term[g];

        bcd_digit u_digit (
            .Clock     (Clock),
            .Reset     (Reset),
            .Load      (Load),
            .LoadDigit (LoadVal[4*g +: 4]),
            .step      (w_carry[g]),
            .Up        (Up),
            .digit     (w_digit[g]),
            .term      (w_term[g])
        );
    end

    assign Count = w_digit;

    // Terminal count: high only in the cycle Count shows the wrapped value.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_tc <= 1'b0;
        end else if (Load) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_carry[DIGITS];
        end
    end

    assign Tc = r_tc;

    // w_hz[i]: digits i..DIGITS-1 are all zero (leading-zero run reaches i).
    logic [DIGITS:1] w_hz;
    assign w_hz[DIGITS] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_hex
        if (g == 0) begin : g_lsd
            // Least significant digit is always shown.
            assign HEX[6:0] = bcd_to_seg(w_digit[0]);
        end else begin : g_upper
            assign w_hz[g] = w_hz[g+1] & (w_digit[g] == 4'd0);
            assign HEX[7*g +: 7] = ((BLANK_LZ != 0) && w_hz[g]) ? SEG_BLANK
                                                                : bcd_to_seg(w_digit[g]);
        end
    end

endmodule
